board_fill_engine: RTL and testbench

Hardware draw engine that renders the chess board background into VRAM. It is a write-side client of the VGA text/palette interface and feeds that block's VRAM port B. On a START command it walks one full frame buffer (80 words x 240 rows; one byte per 2x2-pixel cell, so 320x240 cells) and writes one 32-bit word per accepted cycle. Each byte is a palette index: background, light square or dark square. The engine targets the buffer selected by BUF_SEL, so software can redraw the back buffer while the front buffer is being scanned out.

---
 rtl/board_fill_pkg.sv | 45 ++++
 rtl/board_cell_classifier.sv | 32 +++
 rtl/board_fill_engine.sv | 211 +++++++++++++++++++++
 tb/tb_board_fill_engine.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_fill_pkg.sv
// Shared types and geometry for the chess board background fill engine.
package board_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [7:0] pal_idx_t;

    // VRAM geometry
    localparam int H_WORDS   = 80;
    localparam int V_ROWS    = 240;
    localparam int BUF_WORDS = 19200;

    // Default board geometry (cell units)
    localparam int BOARD_X0 = 60;
    localparam int BOARD_Y0 = 20;
    localparam int SQ_CELLS = 25;
    localparam int N_SQ     = 8;

    // Sized forms of the geometry used by the datapath
    localparam logic [6:0]  LAST_WORD_X   = 7'(H_WORDS - 1);
    localparam logic [6:0]  BOARD_WX0     = 7'(BOARD_X0 / 4);
    localparam logic [7:0]  LAST_ROW      = 8'(V_ROWS - 1);
    localparam logic [7:0]  BOARD_Y0_R    = 8'(BOARD_Y0);
    localparam logic [7:0]  BOARD_Y_END_R = 8'(BOARD_Y0 + N_SQ * SQ_CELLS);
    localparam logic [8:0]  BOARD_X0_C    = 9'(BOARD_X0);
    localparam logic [8:0]  BOARD_X_END_C = 9'(BOARD_X0 + N_SQ * SQ_CELLS);
    localparam logic [5:0]  SQ_CELLS_6    = 6'(SQ_CELLS);
    localparam logic [15:0] BUF_BASE_1    = 16'(BUF_WORDS);

    // Reduce a phase sum (phase + step, step <= 4) back into 0..SQ_CELLS-1.
    function automatic logic [4:0] phase_wrap(input logic [5:0] sum);
        logic [4:0] res;
        if (sum >= SQ_CELLS_6) begin
            res = 5'(sum - SQ_CELLS_6);
        end else begin
            res = sum[4:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/board_cell_classifier.sv
// Combinational classifier: turns one word position plus row/column square
// phase into four palette indices (byte0 = leftmost cell).
module board_cell_classifier
    import board_fill_pkg::*;
(
    input  logic [6:0]  i_word_x,
    input  logic        i_row_in,
    input  logic        i_row_par,
    input  logic [4:0]  i_col_phase,
    input  logic        i_col_par,
    input  pal_idx_t    i_bkg_idx,
    input  pal_idx_t    i_light_idx,
    input  pal_idx_t    i_dark_idx,
    output logic [31:0] o_word
);

    for (genvar k = 0; k < 4; k++) begin : g_cell
        logic [8:0] w_x;
        logic       w_on;
        logic       w_flip;
        logic       w_par;

        // Cell column, board membership and square parity for byte k.
        assign w_x    = {i_word_x, 2'b00} + 9'(k);
        assign w_on   = i_row_in && (w_x >= BOARD_X0_C) && (w_x < BOARD_X_END_C);
        assign w_flip = (({1'b0, i_col_phase} + 6'(k)) >= SQ_CELLS_6);
        assign w_par  = i_col_par ^ w_flip;
        assign o_word[8*k +: 8] = !w_on               ? i_bkg_idx   :
                                  (w_par == i_row_par) ? i_light_idx : i_dark_idx;
    end

endmodule

// File: rtl/board_fill_engine.sv
// Board fill engine: walks one VRAM frame buffer and writes the chess board
// background, one 32-bit word per accepted handshake.
module board_fill_engine
    import board_fill_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_buf_sel,
    input  pal_idx_t    i_bkg_idx,
    input  pal_idx_t    i_light_idx,
    input  pal_idx_t    i_dark_idx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_byte_en,
    input  logic        i_wr_ready
);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_wr_en;
    logic [15:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [3:0]  r_wr_byte_en;

    // Position/phase of the word currently presented on the write port
    logic [6:0]  r_word_x;
    logic [7:0]  r_row;
    logic [4:0]  r_row_phase;
    logic        r_row_par;
    logic [4:0]  r_col_phase;
    logic        r_col_par;

    pal_idx_t    r_bkg_idx;
    pal_idx_t    r_light_idx;
    pal_idx_t    r_dark_idx;

    logic        w_accept;
    logic        w_last_x;
    logic        w_last_word;
    logic        w_cur_row_in;
    logic [5:0]  w_row_sum;
    logic [5:0]  w_col_sum;
    logic [6:0]  w_nx_word_x;
    logic [7:0]  w_nx_row;
    logic [4:0]  w_nx_row_phase;
    logic        w_nx_row_par;
    logic        w_nx_row_in;
    logic [4:0]  w_nx_col_phase;
    logic        w_nx_col_par;
    pal_idx_t    w_cls_bkg;
    pal_idx_t    w_cls_light;
    pal_idx_t    w_cls_dark;
    logic [31:0] w_word;

    assign w_accept     = r_wr_en && i_wr_ready;
    assign w_last_x     = (r_word_x == LAST_WORD_X);
    assign w_last_word  = w_last_x && (r_row == LAST_ROW);
    assign w_cur_row_in = (r_row >= BOARD_Y0_R) && (r_row < BOARD_Y_END_R);
    assign w_row_sum    = {1'b0, r_row_phase} + 6'd1;
    assign w_col_sum    = {1'b0, r_col_phase} + 6'd4;
    assign w_nx_row_in  = (w_nx_row >= BOARD_Y0_R) && (w_nx_row < BOARD_Y_END_R);

    // Next-word position and square phases; in IDLE this is the frame origin.
    always_comb begin
        w_nx_word_x    = 7'd0;
        w_nx_row       = 8'd0;
        w_nx_row_phase = 5'd0;
        w_nx_row_par   = 1'b0;
        w_nx_col_phase = 5'd0;
        w_nx_col_par   = 1'b0;
        w_cls_bkg      = i_bkg_idx;
        w_cls_light    = i_light_idx;
        w_cls_dark     = i_dark_idx;
        if (r_state == IDLE) begin
            w_cls_bkg   = i_bkg_idx;
            w_cls_light = i_light_idx;
            w_cls_dark  = i_dark_idx;
        end else begin
            w_cls_bkg   = r_bkg_idx;
            w_cls_light = r_light_idx;
            w_cls_dark  = r_dark_idx;
            if (w_last_x) begin
                w_nx_word_x = 7'd0;
                w_nx_row    = r_row + 8'd1;
                if (w_cur_row_in) begin
                    w_nx_row_phase = phase_wrap(w_row_sum);
                    w_nx_row_par   = r_row_par ^ (w_row_sum >= SQ_CELLS_6);
                end else begin
                    w_nx_row_phase = r_row_phase;
                    w_nx_row_par   = r_row_par;
                end
            end else begin
                w_nx_word_x    = r_word_x + 7'd1;
                w_nx_row       = r_row;
                w_nx_row_phase = r_row_phase;
                w_nx_row_par   = r_row_par;
            end
            if (w_nx_word_x == BOARD_WX0) begin
                w_nx_col_phase = 5'd0;
                w_nx_col_par   = 1'b0;
            end else begin
                w_nx_col_phase = phase_wrap(w_col_sum);
                w_nx_col_par   = r_col_par ^ (w_col_sum >= SQ_CELLS_6);
            end
        end
    end

    board_cell_classifier u_classifier (
        .i_word_x    (w_nx_word_x),
        .i_row_in    (w_nx_row_in),
        .i_row_par   (w_nx_row_par),
        .i_col_phase (w_nx_col_phase),
        .i_col_par   (w_nx_col_par),
        .i_bkg_idx   (w_cls_bkg),
        .i_light_idx (w_cls_light),
        .i_dark_idx  (w_cls_dark),
        .o_word      (w_word)
    );

    // Control FSM, counters and registered write-port outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 16'd0;
            r_wr_data    <= 32'd0;
            r_wr_byte_en <= 4'd0;
            r_word_x     <= 7'd0;
            r_row        <= 8'd0;
            r_row_phase  <= 5'd0;
            r_row_par    <= 1'b0;
            r_col_phase  <= 5'd0;
            r_col_par    <= 1'b0;
            r_bkg_idx    <= 8'd0;
            r_light_idx  <= 8'd0;
            r_dark_idx   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state      <= FILL;
                        r_busy       <= 1'b1;
                        r_wr_en      <= 1'b1;
                        r_wr_byte_en <= 4'b1111;
                        r_wr_addr    <= i_buf_sel ? BUF_BASE_1 : 16'd0;
                        r_wr_data    <= w_word;
                        r_bkg_idx    <= i_bkg_idx;
                        r_light_idx  <= i_light_idx;
                        r_dark_idx   <= i_dark_idx;
                        r_word_x     <= w_nx_word_x;
                        r_row        <= w_nx_row;
                        r_row_phase  <= w_nx_row_phase;
                        r_row_par    <= w_nx_row_par;
                        r_col_phase  <= w_nx_col_phase;
                        r_col_par    <= w_nx_col_par;
                    end else begin
                        r_busy  <= 1'b0;
                        r_wr_en <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_accept && w_last_word) begin
                        r_state      <= DONE;
                        r_wr_en      <= 1'b0;
                        r_wr_byte_en <= 4'd0;
                        r_done       <= 1'b1;
                    end else if (w_accept) begin
                        r_wr_addr   <= r_wr_addr + 16'd1;
                        r_wr_data   <= w_word;
                        r_word_x    <= w_nx_word_x;
                        r_row       <= w_nx_row;
                        r_row_phase <= w_nx_row_phase;
                        r_row_par   <= w_nx_row_par;
                        r_col_phase <= w_nx_col_phase;
                        r_col_par   <= w_nx_col_par;
                    end else begin
                        r_state <= FILL;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_wr_en      <= 1'b0;
                    r_wr_byte_en <= 4'd0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_byte_en = r_wr_byte_en;

endmodule

// File: tb/tb_board_fill_engine.sv
// Self-checking bench for board_fill_engine against a square-index model.
module tb_board_fill_engine;

    localparam int NW = 19200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        buf_sel;
    logic [7:0]  bkg_idx;
    logic [7:0]  light_idx;
    logic [7:0]  dark_idx;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        wr_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] cap  [0:NW-1];
    logic [31:0] cap0 [0:NW-1];
    int          n_acc;
    int          done_count;
    int          done_at;
    bit          aborted;
    logic [15:0] first_addr;
    logic [15:0] last_addr;

    board_fill_engine dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_buf_sel    (buf_sel),
        .i_bkg_idx    (bkg_idx),
        .i_light_idx  (light_idx),
        .i_dark_idx   (dark_idx),
        .o_busy       (busy),
        .o_done       (done),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_byte_en (wr_byte_en),
        .i_wr_ready   (wr_ready)
    );

    always #5 clk = ~clk;

    // Expected word for linear word index idx: square colour from which
    // 25x25 square of the 8x8 board the cell falls in.
    function automatic logic [31:0] ref_word(input int idx, input logic [7:0] b,
                                             input logic [7:0] l, input logic [7:0] d);
        int row;
        int wx;
        int x;
        logic [31:0] w;
        row = idx / 80;
        wx  = idx % 80;
        w   = 32'd0;
        for (int k = 0; k < 4; k++) begin
            x = 4 * wx + k;
            if (x >= 60 && x < 260 && row >= 20 && row < 220) begin
                w[8*k +: 8] = ((((x - 60) / 25) + ((row - 20) / 25)) % 2 == 0) ? l : d;
            end else begin
                w[8*k +: 8] = b;
            end
        end
        return w;
    endfunction

    // Issue START and follow the whole fill, checking every presented word.
    task automatic run_fill(input logic bs, input logic [7:0] b, input logic [7:0] l,
                            input logic [7:0] d, input bit stall, input bit mid_start,
                            input int abort_at);
        int          base;
        int          cyc;
        int          hold;
        bit          held;
        bit          pulsed;
        bit          seen_done;
        bit          prev_stall;
        logic        rdy;
        logic [15:0] prev_addr;
        logic [31:0] prev_data;
        logic [31:0] exp_data;
        base = bs ? NW : 0;
        hold = 0; held = 0; pulsed = 0; seen_done = 0; prev_stall = 0;
        prev_addr = 16'd0; prev_data = 32'd0;
        n_acc = 0; done_count = 0; done_at = -1; aborted = 0;
        first_addr = 16'hFFFF; last_addr = 16'hFFFF;
        @(negedge clk);
        buf_sel = bs; bkg_idx = b; light_idx = l; dark_idx = d;
        start = 1'b1; wr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        buf_sel = ~bs;
        bkg_idx = 8'($urandom); light_idx = 8'($urandom); dark_idx = 8'($urandom);
        cyc = 1;
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b1) begin
            failures++;
            $display("FAIL start_response busy=%b wr_en=%b required 1/1", busy, wr_en);
        end
        while (!seen_done && cyc < 60000) begin
            if (!stall) begin
                rdy = 1'b1;
            end else if (hold > 0) begin
                rdy = 1'b0; hold--;
            end else if (n_acc == 1000 && !held) begin
                held = 1; hold = 9; rdy = 1'b0;
            end else begin
                rdy = ($urandom_range(3) != 0);
            end
            wr_ready = rdy;
            if (mid_start && !pulsed && n_acc >= 3000) begin
                start = 1'b1; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (wr_en) begin
                exp_data = ref_word(n_acc, b, l, d);
                checks++;
                if (wr_addr !== 16'(base + n_acc)) begin
                    failures++;
                    $display("FAIL wr_addr word=%0d got=%h exp=%h", n_acc, wr_addr, 16'(base + n_acc));
                end
                checks++;
                if (wr_data !== exp_data || wr_byte_en !== 4'b1111) begin
                    failures++;
                    $display("FAIL wr_data word=%0d got=%h/%b exp=%h/1111", n_acc, wr_data, wr_byte_en, exp_data);
                end
                if (prev_stall) begin
                    checks++;
                    if (wr_addr !== prev_addr || wr_data !== prev_data) begin
                        failures++;
                        $display("FAIL stall_stable got=%h/%h exp=%h/%h", wr_addr, wr_data, prev_addr, prev_data);
                    end
                end
                if (abort_at >= 0 && n_acc == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    checks++;
                    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                        failures++;
                        $display("FAIL async_abort wr_en=%b busy=%b done=%b required 0/0/0", wr_en, busy, done);
                    end
                    @(negedge clk);
                    rst_n = 1'b1;
                    aborted = 1;
                    break;
                end
                if (rdy) begin
                    cap[n_acc] = wr_data;
                    if (n_acc == 0) first_addr = wr_addr;
                    last_addr = wr_addr;
                    n_acc++;
                end
                prev_stall = !rdy;
                prev_addr  = wr_addr;
                prev_data  = wr_data;
            end else begin
                checks++;
                if (done !== 1'b1 || wr_byte_en !== 4'd0) begin
                    failures++;
                    $display("FAIL wr_en_gap cycle=%0d done=%b byte_en=%b required 1/0000", cyc, done, wr_byte_en);
                end
                prev_stall = 1'b0;
            end
            if (done) begin
                done_count++; done_at = cyc; seen_done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (seen_done) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin
                failures++;
                $display("FAIL after_done done=%b busy=%b wr_en=%b required 0/0/0", done, busy, wr_en);
            end
        end else if (!aborted) begin
            checks++;
            failures++;
            $display("FAIL fill_timeout accepted=%0d required %0d", n_acc, NW);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; buf_sel = 1'b0; wr_ready = 1'b0;
        bkg_idx = 8'h00; light_idx = 8'h00; dark_idx = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 16'd0 ||
            wr_data !== 32'd0 || wr_byte_en !== 4'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b wr_en=%b addr=%h data=%h be=%b required all 0",
                     busy, done, wr_en, wr_addr, wr_data, wr_byte_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_fill;
        run_fill(1'b0, 8'h01, 8'h11, 8'h22, 1'b0, 1'b0, -1);
        checks++;
        if (done_at != 19201 || done_count != 1 || n_acc != NW) begin
            failures++;
            $display("FAIL basic_fill done_at=%0d pulses=%0d writes=%0d required 19201/1/%0d",
                     done_at, done_count, n_acc, NW);
        end
        checks++;
        if (first_addr !== 16'h0000 || last_addr !== 16'h4AFF) begin
            failures++;
            $display("FAIL buf0_range first=%h last=%h required 0000/4aff", first_addr, last_addr);
        end
        for (int i = 0; i < NW; i++) cap0[i] = cap[i];
    endtask

    task automatic test_board_corner;
        checks++;
        if (cap0[0] !== 32'h01010101) begin
            failures++; $display("FAIL first_word got=%h exp=01010101", cap0[0]);
        end
        checks++;
        if (cap0[1615] !== 32'h11111111) begin
            failures++; $display("FAIL corner_1615 got=%h exp=11111111", cap0[1615]);
        end
        checks++;
        if (cap0[1621] !== 32'h22222211) begin
            failures++; $display("FAIL edge_1621 got=%h exp=22222211", cap0[1621]);
        end
        checks++;
        if (cap0[1664] !== 32'h22222222) begin
            failures++; $display("FAIL right_1664 got=%h exp=22222222", cap0[1664]);
        end
        checks++;
        if (cap0[1665] !== 32'h01010101) begin
            failures++; $display("FAIL outside_1665 got=%h exp=01010101", cap0[1665]);
        end
    endtask

    task automatic test_row_boundary;
        checks++;
        if (cap0[3615] !== 32'h22222222) begin
            failures++; $display("FAIL row45_3615 got=%h exp=22222222", cap0[3615]);
        end
        checks++;
        if (cap0[17535] !== 32'h22222222) begin
            failures++; $display("FAIL row219_17535 got=%h exp=22222222", cap0[17535]);
        end
        checks++;
        if (cap0[17615] !== 32'h01010101) begin
            failures++; $display("FAIL row220_17615 got=%h exp=01010101", cap0[17615]);
        end
    endtask

    task automatic test_buf_sel1;
        int diffs;
        run_fill(1'b1, 8'h01, 8'h11, 8'h22, 1'b0, 1'b0, -1);
        checks++;
        if (first_addr !== 16'h4B00 || last_addr !== 16'h95FF || done_count != 1) begin
            failures++;
            $display("FAIL buf1_range first=%h last=%h pulses=%0d required 4b00/95ff/1",
                     first_addr, last_addr, done_count);
        end
        diffs = 0;
        for (int i = 0; i < NW; i++) if (cap[i] !== cap0[i]) diffs++;
        checks++;
        if (diffs != 0) begin
            failures++; $display("FAIL buf1_contents differing_words=%0d required 0", diffs);
        end
    endtask

    task automatic test_stall;
        run_fill(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1, -1);
        checks++;
        if (done_count != 1 || n_acc != NW) begin
            failures++;
            $display("FAIL stall_fill pulses=%0d writes=%0d required 1/%0d", done_count, n_acc, NW);
        end
    endtask

    task automatic test_abort_restart;
        run_fill(1'b0, 8'h05, 8'h06, 8'h07, 1'b0, 1'b0, 500);
        checks++;
        if (!aborted || done_count != 0 || n_acc != 500) begin
            failures++;
            $display("FAIL abort aborted=%0d pulses=%0d writes=%0d required 1/0/500", aborted, done_count, n_acc);
        end
        run_fill(1'b0, 8'h01, 8'h11, 8'h22, 1'b0, 1'b0, 0);
        checks++;
        if (!aborted || done_count != 0) begin
            failures++;
            $display("FAIL restart aborted=%0d pulses=%0d required 1/0", aborted, done_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_board_corner();
        test_row_boundary();
        test_buf_sel1();
        test_stall();
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
